// File: rtl/data_mem_responder.sv
// Responder for the data-memory load/store port: one request per handshake, a
// programmable access latency, RV32I byte/half/word access and a held response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       MEM_INIT    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_error_q, rsp_error_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;

  // Contents are undefined until written; MEM_INIT is left to external preload.
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [IdxW-1:0] widx;
  logic [31:0]     word, load_data, lane_wdata;
  logic [15:0]     half_v;
  logic [7:0]      byte_v;
  logic [3:0]      be;
  logic            misaligned, out_of_range, bad_funct3, err, commit;

  always_comb begin
    widx         = addr_q[IdxW+1:2];
    word         = mem_q[widx];
    byte_v       = 8'(word >> {addr_q[1:0], 3'b000});
    half_v       = addr_q[1] ? word[31:16] : word[15:0];
    misaligned   = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                   (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    out_of_range = {2'b00, addr_q[31:2]} >= DEPTH_WORDS;
    bad_funct3   = wr_q ? (f3_q >= 3'd3) : (f3_q == 3'd3 || f3_q[2:1] == 2'b11);
    err          = misaligned || out_of_range || bad_funct3;

    case (f3_q)
      3'd0:    load_data = {{24{byte_v[7]}}, byte_v};
      3'd1:    load_data = {{16{half_v[15]}}, half_v};
      3'd2:    load_data = word;
      3'd4:    load_data = {24'b0, byte_v};
      3'd5:    load_data = {16'b0, half_v};
      default: load_data = '0;
    endcase

    // Replicate store data across lanes so the byte enables alone pick the target.
    case (f3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase

    commit = (state_q == StWait) && (cnt_q == '0) && wr_q && !err;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          wr_d        = req_write;
          f3_d        = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = CntW'(WAIT_STATES);
          req_ready_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_error_d = err;
          rsp_rdata_d = (err || wr_q) ? '0 : load_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
